// File: rtl/pipe_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_unit_if
// Brief    : Bundle of the fetch unit's control, instruction-memory and IF/ID
//            handshake signals. "master" is the fetch unit side, "slave" is
//            the surrounding pipeline / memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    // Branch redirect and external stop
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halt;
    // Instruction-memory request channel
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    // Instruction-memory response channel (in request order)
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    // IF/ID delivery channel
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_ir;
    logic [31:0]       if_npc;
    // Status
    logic              fetch_stopped;

    modport master (
        input  redirect_valid, redirect_pc, halt,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_ready,
        output imem_req_valid, imem_addr,
        output if_valid, if_ir, if_npc,
        output fetch_stopped
    );

    modport slave (
        output redirect_valid, redirect_pc, halt,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_ready,
        input  imem_req_valid, imem_addr,
        input  if_valid, if_ir, if_npc,
        input  fetch_stopped
    );
endinterface
`default_nettype wire

// File: rtl/pipe_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_unit
// Brief    : MIPS32 instruction-fetch front end. Issues word-addressed fetches
//            to a variable-latency memory, buffers returned words in an
//            in-order prefetch queue as {IR, NPC}, handles branch redirects
//            (dropping wrong-path responses) and stops after an HLT is queued.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  wire logic         clk1,
    input  wire logic         rst_n,
    pipe_fetch_unit_if.master bus
);
    localparam int                 c_PTR_W      = $clog2(DEPTH);
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_CREDIT_LIM = (c_CNT_W + 1)'(DEPTH);
    localparam logic [5:0]         c_HLT_OP     = 6'b111111;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [31:0]          pc_q,       pc_d;
    logic [c_CNT_W-1:0]   count_q,    count_d;
    logic [c_CNT_W-1:0]   out_q,      out_d;
    logic [c_CNT_W-1:0]   discard_q,  discard_d;
    logic                 hlt_seen_q, hlt_seen_d;
    logic [c_PTR_W-1:0]   q_wr_q,     q_wr_d;
    logic [c_PTR_W-1:0]   q_rd_q,     q_rd_d;
    logic [c_PTR_W-1:0]   tag_wr_q,   tag_wr_d;
    logic [c_PTR_W-1:0]   tag_rd_q,   tag_rd_d;

    // Prefetch queue storage and the address tag of every in-flight fetch
    logic [31:0] ir_mem  [DEPTH];
    logic [31:0] npc_mem [DEPTH];
    logic [31:0] tag_mem [DEPTH];

    logic [c_CNT_W:0] w_inflight;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_is_hlt;
    logic             w_if_valid;
    logic [31:0]      w_rsp_npc;

    // Credit: queued entries plus in-flight fetches never exceed the queue
    // size, so every response that arrives is guaranteed a slot.
    assign w_inflight  = {1'b0, count_q} + {1'b0, out_q};
    assign w_req_valid = rst_n && (state_q == ST_RUN) && !bus.halt
                         && !bus.redirect_valid && (w_inflight < c_CREDIT_LIM);
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop  = bus.imem_rsp_valid && (discard_q != '0);
    assign w_push      = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;
    assign w_if_valid  = (count_q != '0);
    assign w_pop       = w_if_valid && bus.if_ready && !bus.redirect_valid;
    assign w_is_hlt    = (bus.imem_rsp_data[31:26] == c_HLT_OP);
    assign w_rsp_npc   = tag_mem[tag_rd_q] + 32'd1;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = pc_q[ADDR_W-1:0];
    assign bus.if_valid       = w_if_valid;
    assign bus.if_ir          = w_if_valid ? ir_mem[q_rd_q]  : 32'd0;
    assign bus.if_npc         = w_if_valid ? npc_mem[q_rd_q] : 32'd0;
    assign bus.fetch_stopped  = (state_q == ST_STOP);

    // Next-state computation for PC, counters, pointers and run/stop state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        out_d      = out_q;
        discard_d  = discard_q;
        hlt_seen_d = hlt_seen_q;
        q_wr_d     = q_wr_q;
        q_rd_d     = q_rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;

        // In-flight bookkeeping: a response always retires its tag
        if (w_req_fire) begin
            tag_wr_d = tag_wr_q + c_PTR_ONE;
        end
        if (bus.imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + c_PTR_ONE;
        end
        unique case ({w_req_fire, bus.imem_rsp_valid})
            2'b10:   out_d = out_q + c_CNT_ONE;
            2'b01:   out_d = out_q - c_CNT_ONE;
            default: out_d = out_q;
        endcase

        if (bus.redirect_valid) begin
            // Everything still in flight is wrong-path; a response landing
            // this very cycle is dropped here, so it is not counted again.
            pc_d       = bus.redirect_pc;
            discard_d  = bus.imem_rsp_valid ? (out_q - c_CNT_ONE) : out_q;
            count_d    = '0;
            q_wr_d     = '0;
            q_rd_d     = '0;
            hlt_seen_d = 1'b0;
        end else begin
            if (w_req_fire) begin
                pc_d = pc_q + 32'd1;
            end
            if (w_rsp_drop) begin
                discard_d = discard_q - c_CNT_ONE;
            end
            if (w_push) begin
                q_wr_d = q_wr_q + c_PTR_ONE;
                if (w_is_hlt) begin
                    hlt_seen_d = 1'b1;
                end
            end
            if (w_pop) begin
                q_rd_d = q_rd_q + c_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Run/stop: redirect wins unless halt is held; halt level forces
        // STOP; dropping halt resumes only if no HLT has been queued.
        if (bus.redirect_valid && !bus.halt) begin
            state_d = ST_RUN;
        end else if (bus.halt) begin
            state_d = ST_STOP;
        end else if (w_push && w_is_hlt) begin
            state_d = ST_STOP;
        end else if ((state_q == ST_STOP) && !hlt_seen_q) begin
            state_d = ST_RUN;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            out_q      <= '0;
            discard_q  <= '0;
            hlt_seen_q <= 1'b0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            hlt_seen_q <= hlt_seen_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Data storage writes; contents are qualified by the pointers and counts
    always_ff @(posedge clk1) begin
        if (w_push) begin
            ir_mem[q_wr_q]  <= bus.imem_rsp_data;
            npc_mem[q_wr_q] <= w_rsp_npc;
        end
        if (w_req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fetch_unit
// Brief    : Directed self-checking bench for pipe_fetch_unit with an
//            in-order instruction memory model of configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch_unit;
    localparam logic [31:0] c_ADD = 32'h0022_1820;
    localparam logic [31:0] c_SUB = 32'h0022_1822;
    localparam logic [31:0] c_OR  = 32'h0022_1825;
    localparam logic [31:0] c_AND = 32'h0022_1824;
    localparam logic [31:0] c_HLT = 32'hFC00_0000;

    logic clk1 = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   mem_lat = 1;
    int   acc_snap;
    int   acc6_snap;

    logic [31:0] ops [4];
    logic [31:0] mem [1024];

    pipe_fetch_unit_if #(.ADDR_W(10)) bus ();

    pipe_fetch_unit #(
        .ADDR_W   (10),
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    // Memory model: accepts a request, answers it mem_lat cycles later, in order
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] due;
    } pend_t;

    pend_t       pend [$];
    pend_t       pe;
    logic [31:0] cyc         = 32'd0;
    int          n_acc       = 0;
    int          n_acc6      = 0;
    logic        rsp_valid_r = 1'b0;
    logic [31:0] rsp_data_r  = 32'd0;

    assign bus.imem_rsp_valid = rsp_valid_r;
    assign bus.imem_rsp_data  = rsp_data_r;

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
        end else begin
            cyc = cyc + 32'd1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pe.addr = bus.imem_addr;
                pe.due  = cyc + 32'(mem_lat) - 32'd1;
                pend.push_back(pe);
                n_acc = n_acc + 1;
                if (bus.imem_addr == 10'd6) n_acc6 = n_acc6 + 1;
            end
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= mem[pend[0].addr];
                void'(pend.pop_front());
            end else begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk1);
        rst_n              = 1'b0;
        mem_lat            = lat;
        bus.if_ready       = rdy;
        bus.redirect_valid = 1'b0;
        bus.halt           = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        ops[0] = c_ADD; ops[1] = c_SUB; ops[2] = c_OR; ops[3] = c_AND;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 | 32'(i);
        for (int i = 0; i < 4; i++) mem[i] = ops[i];

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b0;

        // Reset values
        repeat (2) @(negedge clk1);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_if_valid",  bus.if_valid, 0);
        chk("rst_if_ir",     bus.if_ir, 0);
        chk("rst_if_npc",    bus.if_npc, 0);
        chk("rst_stopped",   bus.fetch_stopped, 0);

        // Zero-wait streaming, first word two cycles after release
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("t1_req_valid", bus.imem_req_valid, 1);
        chk("t1_addr0",     bus.imem_addr, 0);
        @(negedge clk1);
        chk("t1_if_valid_c1", bus.if_valid, 0);
        chk("t1_addr1",       bus.imem_addr, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            chk("t1_if_valid", bus.if_valid, 1);
            chk("t1_if_ir",    bus.if_ir, ops[i]);
            chk("t1_if_npc",   bus.if_npc, 32'(i + 1));
            chk("t1_addr",     bus.imem_addr, 32'(i + 2));
        end

        // Consumer stalled: credits allow exactly four fetches
        do_reset(1, 1'b0);
        acc_snap = n_acc;
        #1;
        chk("t2_req_valid0", bus.imem_req_valid, 1);
        repeat (4) @(negedge clk1);
        chk("t2_req_stall", bus.imem_req_valid, 0);
        repeat (2) @(negedge clk1);
        chk("t2_accepts",   n_acc - acc_snap, 4);
        chk("t2_req_still", bus.imem_req_valid, 0);
        chk("t2_if_valid",  bus.if_valid, 1);
        chk("t2_head",      bus.if_ir, c_ADD);
        bus.if_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk1);
            chk("t2_drain", bus.if_ir, ops[i]);
            if (i == 1) begin
                chk("t2_req_resume", bus.imem_req_valid, 1);
                chk("t2_addr4",      bus.imem_addr, 4);
            end
        end

        // 3-cycle memory, redirect with three fetches in flight
        do_reset(3, 1'b1);
        repeat (3) @(negedge clk1);
        chk("t3_req_valid", bus.imem_req_valid, 1);
        chk("t3_if_valid",  bus.if_valid, 0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd20;
        #1;
        chk("t3_req_blocked", bus.imem_req_valid, 0);
        @(negedge clk1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_req_after", bus.imem_req_valid, 1);
        chk("t3_addr20",    bus.imem_addr, 20);
        chk("t3_empty",     bus.if_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            chk("t3_dropped", bus.if_valid, 0);
        end
        @(negedge clk1);
        chk("t3_if_valid20", bus.if_valid, 1);
        chk("t3_if_ir20",    bus.if_ir, mem[20]);
        chk("t3_if_npc21",   bus.if_npc, 21);

        // Redirect coinciding with a response and a pop (two in flight)
        do_reset(2, 1'b1);
        repeat (3) @(negedge clk1);
        chk("t4_head", bus.if_ir, c_ADD);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        @(negedge clk1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_cleared", bus.if_valid, 0);
        chk("t4_addr40",  bus.imem_addr, 40);
        @(negedge clk1);
        chk("t4_drop1", bus.if_valid, 0);
        @(negedge clk1);
        chk("t4_wait", bus.if_valid, 0);
        @(negedge clk1);
        chk("t4_if_ir40",  bus.if_ir, mem[40]);
        chk("t4_if_npc41", bus.if_npc, 41);

        // HLT at word 5 stops fetching; redirect resumes
        mem[5] = c_HLT;
        do_reset(1, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd2;
        acc6_snap = n_acc6;
        #1;
        chk("t5_req_redir", bus.imem_req_valid, 0);
        @(negedge clk1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_addr2", bus.imem_addr, 2);
        repeat (4) @(negedge clk1);
        chk("t5_credit_stall", bus.imem_req_valid, 0);
        @(negedge clk1);
        chk("t5_stopped", bus.fetch_stopped, 1);
        chk("t5_head2",   bus.if_ir, mem[2]);
        bus.if_ready = 1'b1;
        for (int i = 3; i < 5; i++) begin
            @(negedge clk1);
            chk("t5_ir",     bus.if_ir, mem[i]);
            chk("t5_no_req", bus.imem_req_valid, 0);
        end
        @(negedge clk1);
        chk("t5_hlt_ir",  bus.if_ir, c_HLT);
        chk("t5_hlt_npc", bus.if_npc, 6);
        @(negedge clk1);
        chk("t5_empty",    bus.if_valid, 0);
        chk("t5_no_req6",  bus.imem_req_valid, 0);
        chk("t5_addr6_cnt", n_acc6 - acc6_snap, 0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        @(negedge clk1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_resumed", bus.fetch_stopped, 0);
        chk("t5_req_on",  bus.imem_req_valid, 1);
        chk("t5_addr0",   bus.imem_addr, 0);

        // Halt level
        bus.halt = 1'b1;
        #1;
        chk("halt_req_off", bus.imem_req_valid, 0);
        @(negedge clk1);
        chk("halt_stopped", bus.fetch_stopped, 1);
        bus.halt = 1'b0;
        #1;
        chk("halt_still_off", bus.imem_req_valid, 0);
        @(negedge clk1);
        chk("halt_run",    bus.fetch_stopped, 0);
        chk("halt_req_on", bus.imem_req_valid, 1);

        // Asynchronous reset with a full queue
        do_reset(1, 1'b0);
        repeat (6) @(negedge clk1);
        chk("t6_full", bus.if_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_if_valid", bus.if_valid, 0);
        chk("t6_if_ir",    bus.if_ir, 0);
        chk("t6_req",      bus.imem_req_valid, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        chk("t6_addr_rst", bus.imem_addr, 0);
        chk("t6_req_on",   bus.imem_req_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
